// File: rtl/nor_gate_sweeper.sv
// nor_gate_sweeper: an N-input logic gate with a run-time selectable function
// and registered outputs. It has two modes:
//   - direct mode evaluates the operands presented on in_data;
//   - sweep mode walks every input combination in hardware and records the
//     complete truth table of the latched function.
// It is intended as an on-chip exerciser/checker for the gate library.
module nor_gate_sweeper #(
    parameter int N_INPUTS = 2,
    parameter int TT_W     = 2**N_INPUTS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          op,
    input  logic                in_valid,
    input  logic [N_INPUTS-1:0] in_data,
    input  logic                start,
    output logic                out_valid,
    output logic                out_data,
    output logic [N_INPUTS-1:0] sweep_idx,
    output logic                busy,
    output logic                done,
    output logic [TT_W-1:0]     truth_table
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // The final combination of the walk. The index never wraps past this
    // value, so a sweep emits exactly TT_W results.
    localparam logic [N_INPUTS-1:0] IDX_LAST = N_INPUTS'(TT_W - 1);

    state_t              state;
    logic [2:0]          op_q;
    logic [N_INPUTS-1:0] idx;

    logic direct_bit;
    logic sweep_bit;

    // Gate function. Ops 0-5 reduce over every input bit. BUF and NOT look
    // only at bit 0.
    function automatic logic gate_eval(input logic [2:0]          f_op,
                                       input logic [N_INPUTS-1:0] x);
        logic r;
        r = 1'b0;
        case (f_op)
            3'd0: r =  (&x);
            3'd1: r =  (|x);
            3'd2: r = ~(&x);
            3'd3: r = ~(|x);
            3'd4: r =  (^x);
            3'd5: r = ~(^x);
            3'd6: r =  x[0];
            3'd7: r = ~x[0];
        endcase
        return r;
    endfunction

    // Direct mode uses the live op. Sweep mode uses the op latched at start,
    // so that toggling op mid-sweep does not disturb the table.
    assign direct_bit = gate_eval(op, in_data);
    assign sweep_bit  = gate_eval(op_q, idx);

    // ---- output register stage: FSM and all registered outputs ----
    // Control FSM (IDLE -> SWEEP -> DONE -> IDLE) together with every
    // registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            sweep_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            op_q        <= '0;
            idx         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // start wins. A simultaneous operand strobe is dropped.
                        op_q        <= op;
                        idx         <= '0;
                        truth_table <= '0;
                        busy        <= 1'b1;
                        out_valid   <= 1'b0;
                        state       <= S_SWEEP;
                    end else if (in_valid) begin
                        out_data  <= direct_bit;
                        sweep_idx <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end

                S_SWEEP: begin
                    out_data         <= sweep_bit;
                    sweep_idx        <= idx;
                    out_valid        <= 1'b1;
                    truth_table[idx] <= sweep_bit;
                    if (idx == IDX_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    // Single cycle in which done and the complete table are
                    // visible. start and in_valid are ignored here.
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_gate_sweeper.sv
// Testbench for nor_gate_sweeper. Two instances are used, with N_INPUTS=2
// and N_INPUTS=3. A popcount-based reference model of the gate functions
// supplies every expected value.
module tb_nor_gate_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // N_INPUTS = 2 instance
    logic       rst2, in_valid2, start2;
    logic [2:0] op2;
    logic [1:0] in_data2;
    logic       out_valid2, out_data2, busy2, done2;
    logic [1:0] sweep_idx2;
    logic [3:0] tt2;

    // N_INPUTS = 3 instance
    logic       rst3, in_valid3, start3;
    logic [2:0] op3;
    logic [2:0] in_data3;
    logic       out_valid3, out_data3, busy3, done3;
    logic [2:0] sweep_idx3;
    logic [7:0] tt3;

    nor_gate_sweeper #(.N_INPUTS(2)) dut2 (
        .clk(clk), .rst(rst2), .op(op2), .in_valid(in_valid2), .in_data(in_data2),
        .start(start2), .out_valid(out_valid2), .out_data(out_data2),
        .sweep_idx(sweep_idx2), .busy(busy2), .done(done2), .truth_table(tt2)
    );

    nor_gate_sweeper #(.N_INPUTS(3)) dut3 (
        .clk(clk), .rst(rst3), .op(op3), .in_valid(in_valid3), .in_data(in_data3),
        .start(start3), .out_valid(out_valid3), .out_data(out_data3),
        .sweep_idx(sweep_idx3), .busy(busy3), .done(done3), .truth_table(tt3)
    );

    // Reference: gate result from the count of ones among the n inputs.
    function automatic logic ref_f(input int n, input logic [2:0] o, input int x);
        int ones;
        ones = $countones(x & ((1 << n) - 1));
        case (o)
            3'd0: return ones == n;
            3'd1: return ones != 0;
            3'd2: return ones != n;
            3'd3: return ones == 0;
            3'd4: return (ones % 2) == 1;
            3'd5: return (ones % 2) == 0;
            3'd6: return (x % 2) == 1;
            default: return (x % 2) == 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_tt(input int n, input logic [2:0] o);
        logic [31:0] t;
        t = '0;
        for (int k = 0; k < (1 << n); k++) t[k] = ref_f(n, o, k);
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic r, input logic s, input logic iv,
                         input logic [2:0] o, input logic [7:0] d);
        if (n == 2) begin
            rst2 = r; start2 = s; in_valid2 = iv; op2 = o; in_data2 = d[1:0];
        end else begin
            rst3 = r; start3 = s; in_valid3 = iv; op3 = o; in_data3 = d[2:0];
        end
    endtask

    task automatic sample(input int n, output logic [31:0] ov, output logic [31:0] od,
                          output logic [31:0] si, output logic [31:0] bz,
                          output logic [31:0] dn, output logic [31:0] tt);
        if (n == 2) begin
            ov = 32'(out_valid2); od = 32'(out_data2); si = 32'(sweep_idx2);
            bz = 32'(busy2);      dn = 32'(done2);     tt = 32'(tt2);
        end else begin
            ov = 32'(out_valid3); od = 32'(out_data3); si = 32'(sweep_idx3);
            bz = 32'(busy3);      dn = 32'(done3);     tt = 32'(tt3);
        end
    endtask

    task automatic check_all_zero(input int n, input string tag);
        logic [31:0] ov, od, si, bz, dn, tt;
        sample(n, ov, od, si, bz, dn, tt);
        check({tag, "_out_valid"}, ov, 0);
        check({tag, "_out_data"},  od, 0);
        check({tag, "_sweep_idx"}, si, 0);
        check({tag, "_busy"},      bz, 0);
        check({tag, "_done"},      dn, 0);
        check({tag, "_tt"},        tt, 0);
    endtask

    // Full sweep. With disturb set, start/in_valid/op/in_data are scrambled
    // while busy and during the DONE cycle; none of that may change anything.
    task automatic run_sweep(input int n, input logic [2:0] o, input bit disturb,
                             input bit with_inv, input string tag,
                             output logic [31:0] tt_out);
        logic [31:0] ov, od, si, bz, dn, tt, exp_tt;
        int last;
        last   = (1 << n) - 1;
        exp_tt = ref_tt(n, o);
        drive(n, 1'b0, 1'b0, 1'b0, o, 8'd0);
        tick();
        drive(n, 1'b0, 1'b1, with_inv, o, 8'($urandom));
        tick();
        sample(n, ov, od, si, bz, dn, tt);
        check({tag, "_start_busy"}, bz, 1);
        check({tag, "_start_no_ov"}, ov, 0);
        check({tag, "_start_tt_clr"}, tt, 0);
        check({tag, "_start_done"}, dn, 0);
        for (int k = 0; k <= last; k++) begin
            if (disturb)
                drive(n, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
            else
                drive(n, 1'b0, 1'b0, 1'b0, o, 8'd0);
            tick();
            sample(n, ov, od, si, bz, dn, tt);
            check({tag, "_ov"},   ov, 1);
            check({tag, "_idx"},  si, 32'(k));
            check({tag, "_data"}, od, 32'(ref_f(n, o, k)));
            check({tag, "_busy"}, bz, 32'(k != last));
            check({tag, "_done"}, dn, 32'(k == last));
        end
        check({tag, "_tt"}, tt, exp_tt);
        tt_out = tt;
        if (disturb)
            drive(n, 1'b0, 1'b1, 1'b1, 3'($urandom), 8'($urandom));
        else
            drive(n, 1'b0, 1'b0, 1'b0, o, 8'd0);
        tick();
        sample(n, ov, od, si, bz, dn, tt);
        check({tag, "_post_ov"},   ov, 0);
        check({tag, "_post_done"}, dn, 0);
        check({tag, "_post_busy"}, bz, 0);
        check({tag, "_post_tt"},   tt, exp_tt);
        drive(n, 1'b0, 1'b0, 1'b0, o, 8'd0);
        tick();
        sample(n, ov, od, si, bz, dn, tt);
        check({tag, "_idle_busy"}, bz, 0);
        check({tag, "_idle_ov"},   ov, 0);
    endtask

    initial begin
        logic [31:0] ov, od, si, bz, dn, tt, got_tt;
        logic [2:0]  ro;
        logic [7:0]  rd;
        logic        riv;
        logic        nor_exp [4];
        nor_exp = '{1'b1, 1'b0, 1'b0, 1'b0};

        // Power-on reset
        drive(2, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        drive(3, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        tick();
        tick();
        check_all_zero(2, "por2");
        check_all_zero(3, "por3");
        drive(2, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        drive(3, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        tick();

        // Direct NOR on N=2, back-to-back strobes
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b0, 1'b0, 1'b1, 3'd3, 8'(i));
            tick();
            sample(2, ov, od, si, bz, dn, tt);
            check("dnor_ov",   ov, 1);
            check("dnor_data", od, 32'(nor_exp[i]));
            check("dnor_idx",  si, 0);
        end
        drive(2, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);
        tick();
        sample(2, ov, od, si, bz, dn, tt);
        check("dnor_end_ov", ov, 0);

        // Sweep NOR on N=2
        run_sweep(2, 3'd3, 1'b0, 1'b0, "snor2", got_tt);
        check("snor2_const", got_tt, 32'h1);

        // Random direct traffic on N=3
        for (int i = 0; i < 24; i++) begin
            ro  = 3'($urandom);
            rd  = 8'($urandom);
            riv = ($urandom_range(0, 3) != 0);
            drive(3, 1'b0, 1'b0, riv, ro, rd);
            tick();
            sample(3, ov, od, si, bz, dn, tt);
            check("rdir_ov", ov, 32'(riv));
            if (riv) begin
                check("rdir_data", od, 32'(ref_f(3, ro, int'(rd[2:0]))));
                check("rdir_idx",  si, 0);
            end
        end

        // XOR and NAND sweeps on N=3 with inputs scrambled mid-sweep
        run_sweep(3, 3'd4, 1'b1, 1'b0, "sxor3", got_tt);
        check("sxor3_const", got_tt, 32'h96);
        run_sweep(3, 3'd2, 1'b1, 1'b0, "snand3", got_tt);
        check("snand3_const", got_tt, 32'h7F);

        // start and in_valid together: the sweep runs, no direct result
        run_sweep(3, 3'd3, 1'b0, 1'b1, "sinv3", got_tt);
        run_sweep(2, 3'd4, 1'b1, 1'b1, "sinv2", got_tt);

        // Random-op sweeps
        for (int i = 0; i < 3; i++) begin
            run_sweep(3, 3'($urandom), 1'b1, 1'($urandom), "srnd3", got_tt);
            run_sweep(2, 3'($urandom), 1'b1, 1'($urandom), "srnd2", got_tt);
        end

        // Reset at sweep_idx==2 on N=3
        drive(3, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        tick();
        drive(3, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        tick();
        tick();
        tick();
        sample(3, ov, od, si, bz, dn, tt);
        check("mid_idx", si, 2);
        check("mid_busy", bz, 1);
        drive(3, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        tick();
        check_all_zero(3, "midrst");
        drive(3, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            sample(3, ov, od, si, bz, dn, tt);
            check("midrst_no_done", dn, 0);
            check("midrst_no_ov",   ov, 0);
            check("midrst_no_busy", bz, 0);
        end
        run_sweep(3, 3'd0, 1'b0, 1'b0, "fresh3", got_tt);
        check("fresh3_const", got_tt, 32'h80);

        // Reset held for 2 cycles during direct traffic on N=2
        drive(2, 1'b0, 1'b0, 1'b1, 3'd1, 8'd3);
        tick();
        sample(2, ov, od, si, bz, dn, tt);
        check("dir_pre_rst_ov", ov, 1);
        drive(2, 1'b1, 1'b0, 1'b1, 3'd1, 8'd3);
        tick();
        tick();
        check_all_zero(2, "rst2cyc");
        drive(2, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
